// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
// Line levels, frame states and the parity helper.
package uart_pkg;

  localparam int MAX_DW = 32;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Zero-extension of narrower words leaves parity unchanged.
  function automatic logic even_parity(
    input logic [MAX_DW-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer for the UART transmitter.
// tick marks the last clk cycle of each bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Count within the bit, wrap on the boundary, hold at 0 while cleared.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read side feeding a UART serialiser (8N1, opt. parity/2 stop).
// Pops one word per frame, only when idle, enabled and non-empty.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STP = BW'(STOP_BITS - 1);

  tx_state_e state_q;
  tx_state_e state_d;

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [BW-1:0]         bit_q;
  logic [BW-1:0]         bit_d;
  logic                  par_q;
  logic                  par_d;
  logic                  tx_q;
  logic                  tx_d;

  logic tick;
  logic clr;
  logic last_bit;
  logic last_stp;

  assign clr      = (state_q == IDLE) || (state_q == LOAD);
  assign last_bit = (bit_q == LAST_BIT);
  assign last_stp = (bit_q == LAST_STP);
  assign tx       = tx_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .tick(tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Frame sequencing: advance on bit boundaries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (fifo_rd_en) state_d = LOAD;
      LOAD:   state_d = START;
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick && last_bit) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick && last_stp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs; reset masks the pop strobe.
  always_comb begin
    fifo_rd_en = !rst && (state_q == IDLE) && tx_en && !fifo_empty;
    busy       = (state_q != IDLE);
    frame_done = (state_q == STOP) && tick && last_stp;
  end

  // Datapath next values; tx follows the state being entered.
  always_comb begin
    shreg_d = shreg_q;
    bit_d   = bit_q;
    par_d   = par_q;
    unique case (state_q)
      LOAD: begin
        shreg_d = fifo_data;
        par_d   = even_parity(MAX_DW'(fifo_data));
        bit_d   = '0;
      end
      DATA: begin
        if (tick) begin
          if (last_bit) begin
            bit_d = '0;
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) bit_d = last_stp ? '0 : bit_q + BW'(1);
      end
      default: bit_d = '0;
    endcase
    unique case (state_d)
      START:   tx_d = SPACE;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_q;
      default: tx_d = MARK;
    endcase
  end

  // Datapath registers; line returns to mark on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= MARK;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with two FIFO models.
// dut0: 8N1, dut1: even parity; both CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       tx_en0, tx_en1;
  logic       emp0, emp1;
  logic [7:0] fd0, fd1;
  logic       rd0, rd1;
  logic       tx0, tx1;
  logic       busy0, busy1;
  logic       done0, done1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done = 0;
  int viol = 0;

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(0), .STOP_BITS(1)
  ) dut0 (
    .clk(clk), .rst(rst), .tx_en(tx_en0),
    .fifo_empty(emp0), .fifo_data(fd0),
    .fifo_rd_en(rd0), .tx(tx0),
    .busy(busy0), .frame_done(done0)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(8), .CLKS_PER_BIT(CPB),
    .PARITY_EN(1), .STOP_BITS(1)
  ) dut1 (
    .clk(clk), .rst(rst), .tx_en(tx_en1),
    .fifo_empty(emp1), .fifo_data(fd1),
    .fifo_rd_en(rd1), .tx(tx1),
    .busy(busy1), .frame_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  assign emp0 = (q0.size() == 0);
  assign emp1 = (q1.size() == 0);

  // FIFO models: registered data_out, valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd0) begin
      if (q0.size() == 0) viol++;
      else fd0 <= q0.pop_front();
    end
    if (rd1) begin
      if (q1.size() == 0) viol++;
      else fd1 <= q1.pop_front();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               n, act, exp);
    end
  endtask

  function automatic logic rd_of(input bit s);
    return s ? rd1 : rd0;
  endfunction
  function automatic logic tx_of(input bit s);
    return s ? tx1 : tx0;
  endfunction
  function automatic logic busy_of(input bit s);
    return s ? busy1 : busy0;
  endfunction
  function automatic logic done_of(input bit s);
    return s ? done1 : done0;
  endfunction

  // Wait for a pop, then check LOAD and every bit of the frame.
  task automatic play_frame(input bit sel,
                            input string exp,
                            input bit chk_gap,
                            input int drop_bit);
    int w;
    int nfd;
    int bad;
    logic [CPB-1:0] seen;
    logic [CPB-1:0] want;
    logic e;
    bit last;
    w = 0;
    #1;
    while (!rd_of(sel) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rd_en_seen", {31'd0, rd_of(sel)}, 1);
    if (!rd_of(sel)) return;
    if (chk_gap) chk("gap_cycles", cyc - last_done, 1);
    @(negedge clk);
    chk("load_tx", {31'd0, tx_of(sel)}, 1);
    chk("load_busy", {31'd0, busy_of(sel)}, 1);
    nfd = 0;
    bad = 0;
    for (int b = 0; b < exp.len(); b++) begin
      e = (exp[b] == "1");
      want = {CPB{e}};
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        if (b == drop_bit && k == 0) begin
          if (sel) tx_en1 = 1'b0;
          else     tx_en0 = 1'b0;
        end
        seen[k] = tx_of(sel);
        last = (b == exp.len() - 1) && (k == CPB - 1);
        if (busy_of(sel) !== 1'b1) bad++;
        if (rd_of(sel) !== 1'b0) bad++;
        if (done_of(sel) === 1'b1) nfd++;
        if (done_of(sel) !== last) bad++;
        if (last) last_done = cyc;
      end
      chk($sformatf("tx_bit%0d", b), 32'(seen), 32'(want));
    end
    chk("frame_done_count", nfd, 1);
    chk("in_frame_flags", bad, 0);
  endtask

  // Line must stay quiet: no pop, mark, not busy.
  task automatic quiet(input bit sel, input int n,
                       input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rd_of(sel) !== 1'b0) bad++;
      if (tx_of(sel) !== 1'b1) bad++;
      if (busy_of(sel) !== 1'b0) bad++;
    end
    chk(name, bad, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         sel;
    bit         first;
    string      exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int j;
    int w;
    tbl[0] = '{8'h00, 1'b0, 1'b1, "0000000001"};
    tbl[1] = '{8'hFF, 1'b0, 1'b0, "0111111111"};
    tbl[2] = '{8'h55, 1'b0, 1'b0, "0101010101"};
    tbl[3] = '{8'h07, 1'b1, 1'b1, "01110000011"};
    tbl[4] = '{8'h03, 1'b1, 1'b1, "01100000001"};

    rst = 1'b1;
    tx_en0 = 1'b1;
    tx_en1 = 1'b1;
    fd0 = '0;
    fd1 = '0;
    q0.push_back(8'hA5);

    // Reset with data waiting.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", {31'd0, tx0}, 1);
      chk("rst_rd_busy_done",
          {29'd0, rd0, busy0, done0}, 0);
    end
    rst = 1'b0;

    // Single byte 0xA5.
    play_frame(1'b0, "0101001011", 1'b0, -1);
    quiet(1'b0, 10, "idle_after_a5");
    chk("a5_popped", q0.size(), 0);

    // Table: bursts and parity frames.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].first) begin
        j = i;
        while (j < 5 && (j == i || !tbl[j].first)) begin
          if (tbl[j].sel) q1.push_back(tbl[j].data);
          else            q0.push_back(tbl[j].data);
          j++;
        end
      end
      play_frame(tbl[i].sel, tbl[i].exp,
                 !tbl[i].first, -1);
      if (i == 4 || tbl[i+1].first) begin
        quiet(tbl[i].sel, 10, "idle_after_group");
      end
    end

    // Empty FIFO with tx_en high.
    quiet(1'b0, 100, "empty_no_pop");

    // Data present, tx_en low.
    tx_en0 = 1'b0;
    q0.push_back(8'h5A);
    q0.push_back(8'h35);
    quiet(1'b0, 20, "txen_low_no_pop");
    chk("txen_low_level", q0.size(), 2);

    // tx_en dropped during the frame.
    tx_en0 = 1'b1;
    play_frame(1'b0, "0010110101", 1'b0, 3);
    quiet(1'b0, 20, "after_drop_no_pop");
    chk("after_drop_level", q0.size(), 1);

    // Reset during data bit 3 of 0x35.
    tx_en0 = 1'b1;
    w = 0;
    #1;
    while (!rd0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst_mid_rd_seen", {31'd0, rd0}, 1);
    repeat (19) @(negedge clk);
    chk("bit3_tx", {31'd0, tx0}, 0);
    chk("bit3_busy", {31'd0, busy0}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx", {31'd0, tx0}, 1);
    chk("rst_mid_busy", {31'd0, busy0}, 0);
    rst = 1'b0;
    quiet(1'b0, 10, "after_rst_no_pop");
    chk("rst_byte_gone", q0.size(), 0);
    q0.push_back(8'hA5);
    play_frame(1'b0, "0101001011", 1'b0, -1);
    quiet(1'b0, 5, "final_idle");

    chk("rd_while_empty", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
